pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised, handshaked pipeline-stage register that generalises the fixed inter-stage latches of the core pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width data payload plus a control-bit field, and supports per-stage stall through valid/ready backpressure. Flush turns the stage into a bubble by zeroing its control bits. An optional skid buffer registers the upstream ready path, so that long stall chains do not form combinational ready paths.

## Interface
- DATA_W, 64, payload width in bits (ALU result, store data, PC target, rd, ...); must be ≥1.
- CTRL_W, 4, control-bit width (branch, memtoreg, memwrite, regwrite, ...); must be ≥1; these bits are zeroed on flush and when empty.
- CLEAR_DATA, 0, when 1, data registers are also zeroed on flush and when an entry empties; when 0, data holds its stale value.
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage accepts a beat this cycle.
- in_data  input  DATA_W  upstream payload.
- in_ctrl  input  CTRL_W  upstream control bits.
- flush  input  1  synchronous squash of all held and incoming beats.
- out_valid  output  1  downstream beat present.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  held payload.
- out_ctrl  output  CTRL_W  held control bits; 0 whenever out_valid=0.
- stall_cnt  output  16  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_*); with the skid option, one additional skid register.
- States, with the skid option:
  - EMPTY: in_fire → ONE (main←in).
  - ONE:
    - in_fire & out_fire → ONE (main←in).
    - in_fire & !out_fire → TWO (skid←in).
    - !in_fire & out_fire → EMPTY.
    - Otherwise hold.
  - TWO: in_ready=0; out_fire → ONE (main←skid); otherwise hold.
- States, without the skid option:
  - EMPTY: in_fire → FULL.
  - FULL: in_fire → FULL (main←in); out_fire & !in_fire → EMPTY.
- Flush has the highest priority: next state is EMPTY, all ctrl registers ←0, and data registers ←0 if CLEAR_DATA. A beat presented with flush is discarded even if in_ready=1. An out_fire in the same cycle still counts as delivered.
- Every entry that empties gets ctrl←0 (data←0 if CLEAR_DATA). Consequence: out_ctrl=0 whenever out_valid=0.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at 16'hFFFF; no wrap.
  - Cleared only by reset; unaffected by flush.
- While in_valid=1 & in_ready=0, upstream must hold in_data/in_ctrl stable. The stage never drops an accepted beat, except on flush.

## Timing
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0, state EMPTY.
  - in_ready=1, for both the skid and non-skid builds.
- Latency: an accepted beat appears on out_* the cycle after in_fire.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- in_ready:
  - With the skid option: a register output, equal to (next state ≠ TWO). It drops the cycle after the first stalled accept.
  - Without the skid option: combinational, !out_valid | out_ready.
- Flush takes effect at the next edge: out_valid=0 in the cycle after flush. in_ready=1 in that cycle.
- Reset mid-transfer: all state is lost immediately; no beat is emitted after reset release until a new in_fire.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - Skid register and 3-state FSM are built; in_ready is registered.
  - Up to 2 beats are held; there is no combinational path from out_ready to in_ready.
- Undefined:
  - Single register, 2-state behaviour; in_ready is combinational from out_ready.
  - At most 1 beat is held; the skid logic is absent.

## Test plan
- Reset release, in_valid=1, in_data=0xA5A5, in_ctrl=4'b1011, out_ready=1 → next cycle out_valid=1, out_data=0xA5A5, out_ctrl=4'b1011; stream of 8 beats emerges in order at 1/cycle.
- Skid build: beats D0, D1, D2 offered with out_ready=0 → D0 in main, D1 in skid, in_ready=0 from the 3rd cycle, D2 held upstream. After out_ready=1: D0, D1, D2 delivered in consecutive cycles, none lost.
- Flush while two beats are held and in_valid=1, CLEAR_DATA=0 → next cycle out_valid=0, out_ctrl=0, in_ready=1; the incoming beat is not delivered.
- Flush, CLEAR_DATA=1 → out_data=0 and out_ctrl=0 the cycle after flush.
- out_valid=1 with out_ready=0 for 70000 cycles → stall_cnt=16'hFFFF and holds; reset → 0; a flush mid-count leaves stall_cnt unchanged.
- Assert reset_n=0 asynchronously mid-stream, between edges → out_valid, out_data, out_ctrl and stall_cnt go to 0 immediately; after release, out_valid stays 0 until a new in_fire.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Handshaked pipeline-stage register carrying a DATA_W payload and a CTRL_W
//   control field between core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   A flush turns the stage into a bubble by zeroing the control bits. When an
//   entry empties, its control bits are also zeroed, so out_ctrl is 0 whenever
//   out_valid is 0.
//
//   Build option: define PIPE_STAGE_SKID_EN to add a skid register and a
//   3-state FSM. In that build in_ready comes straight from a flop, so there
//   is no combinational path from out_ready to in_ready. Without the macro the
//   stage is a single register, and in_ready = !out_valid | out_ready.
//
// Parameters
//   DATA_W      payload width (>=1)
//   CTRL_W      control-bit width (>=1)
//   CLEAR_DATA  1: payload registers are zeroed on flush and when an entry
//               empties. 0: the payload keeps its stale value.
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   upstream beat present
//   in_ready   stage accepts a beat this cycle
//   in_data    upstream payload
//   in_ctrl    upstream control bits
//   flush      synchronous squash of held and incoming beats
//   out_valid  downstream beat present
//   out_ready  downstream accepts
//   out_data   held payload
//   out_ctrl   held control bits (0 when out_valid=0)
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
module pipe_stage_reg #(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 4,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       stall_cnt
);

  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] data_p0;
  logic [CTRL_W-1:0] ctrl_p0;

  // Payload value an entry takes when it empties or is flushed.
  function automatic logic [DATA_W-1:0] empty_data(input logic [DATA_W-1:0] d);
    return (CLEAR_DATA != 0) ? '0 : d;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign out_fire = out_valid & out_ready;
  assign out_data = data_p0;
  assign out_ctrl = ctrl_p0;

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t            state, state_nxt;
  logic              in_ready_q;
  logic [DATA_W-1:0] data_p1;
  logic [CTRL_W-1:0] ctrl_p1;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != S_EMPTY);
  assign in_fire   = in_valid & in_ready_q;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (in_fire) state_nxt = S_ONE;
        S_ONE: begin
          if (in_fire && !out_fire)      state_nxt = S_TWO;
          else if (!in_fire && out_fire) state_nxt = S_EMPTY;
        end
        S_TWO:   if (out_fire) state_nxt = S_ONE;
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // in_ready is the registered form of (next state != TWO).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != S_TWO);
    end
  end

  // Stage boundary: main entry (p0) drives out_*, skid entry (p1) backs it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_p0 <= '0;
      ctrl_p0 <= '0;
      data_p1 <= '0;
      ctrl_p1 <= '0;
    end else if (flush) begin
      data_p0 <= empty_data(data_p0);
      ctrl_p0 <= '0;
      data_p1 <= empty_data(data_p1);
      ctrl_p1 <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_fire) begin
            data_p0 <= in_data;
            ctrl_p0 <= in_ctrl;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            data_p0 <= in_data;
            ctrl_p0 <= in_ctrl;
          end else if (in_fire) begin
            data_p1 <= in_data;
            ctrl_p1 <= in_ctrl;
          end else if (out_fire) begin
            data_p0 <= empty_data(data_p0);
            ctrl_p0 <= '0;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            data_p0 <= data_p1;
            ctrl_p0 <= ctrl_p1;
            data_p1 <= empty_data(data_p1);
            ctrl_p1 <= '0;
          end
        end
        default: ;
      endcase
    end
  end
`else
  logic vld_p0;

  assign out_valid = vld_p0;
  assign in_ready  = !vld_p0 | out_ready;
  assign in_fire   = in_valid & in_ready;

  // Stage boundary: single register (p0) drives out_*.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      ctrl_p0 <= '0;
    end else if (flush) begin
      vld_p0  <= 1'b0;
      data_p0 <= empty_data(data_p0);
      ctrl_p0 <= '0;
    end else if (in_fire) begin
      vld_p0  <= 1'b1;
      data_p0 <= in_data;
      ctrl_p0 <= in_ctrl;
    end else if (out_fire) begin
      vld_p0  <= 1'b0;
      data_p0 <= empty_data(data_p0);
      ctrl_p0 <= '0;
    end
  end
`endif

  // Flush does not touch the stall counter; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 16'd0;
    end else if (out_valid && !out_ready) begin
      stall_cnt <= sat_inc16(stall_cnt);
    end
  end

endmodule
